// File: rtl/codma_pkg.sv
// codma_pkg: sequencer state encoding, bus size codes, chunk byte counts and
// error codes shared by the CODMA control stage.
package codma_pkg;

  typedef logic [2:0] seq_state_t;

  // Sequencer states (plain constants so legacy tools can read the encoding)
  localparam logic [2:0] SEQ_IDLE    = 3'd0;
  localparam logic [2:0] SEQ_CHECK   = 3'd1;
  localparam logic [2:0] SEQ_RD_REQ  = 3'd2;
  localparam logic [2:0] SEQ_RD_WAIT = 3'd3;
  localparam logic [2:0] SEQ_WR_REQ  = 3'd4;
  localparam logic [2:0] SEQ_WR_WAIT = 3'd5;
  localparam logic [2:0] SEQ_DONE    = 3'd6;
  localparam logic [2:0] SEQ_ERR     = 3'd7;

  // Bus size codes understood by the read/write machines
  localparam logic [7:0] SIZE_8W = 8'd9;
  localparam logic [7:0] SIZE_4W = 8'd8;
  localparam logic [7:0] SIZE_2W = 8'd3;

  // Bytes moved by one chunk of each size
  localparam logic [5:0] BYTES_8W = 6'd32;
  localparam logic [5:0] BYTES_4W = 6'd16;
  localparam logic [5:0] BYTES_2W = 6'd8;

  // Task error codes
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BUS   = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

endpackage

// File: rtl/read_pkg.sv
// read_pkg: state encoding published by read_machine, observed by the sequencer.
package read_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    RD_RESP = 2'd3
  } read_state_t;

endpackage

// File: rtl/write_pkg.sv
// write_pkg: state encoding published by write_machine, observed by the sequencer.
package write_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } write_state_t;

endpackage

// File: rtl/codma_chunk_sel.sv
// codma_chunk_sel: picks the largest bus chunk that fits in the remaining
// byte count (32, then 16, then 8 bytes). Purely combinational.
module codma_chunk_sel
  import codma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [LEN_W-1:0] remaining_i,
  output logic [7:0]       size_o,
  output logic [5:0]       bytes_o
);

  // Largest chunk not exceeding the remaining length
  always_comb begin
    if (remaining_i >= LEN_W'(BYTES_8W)) begin
      size_o  = SIZE_8W;
      bytes_o = BYTES_8W;
    end else if (remaining_i >= LEN_W'(BYTES_4W)) begin
      size_o  = SIZE_4W;
      bytes_o = BYTES_4W;
    end else begin
      size_o  = SIZE_2W;
      bytes_o = BYTES_2W;
    end
  end

endmodule

// File: rtl/codma_task_sequencer.sv
// codma_task_sequencer: splits one copy task into 32/16/8-byte chunks and
// hands each chunk first to read_machine, then to write_machine.
// Optional build macro: CODMA_ALIGN_CHECK_EN adds an 8-byte address
// alignment check (error code 3) to the task validation step.
module codma_task_sequencer
  import codma_pkg::*, read_pkg::*, write_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_code_o,
  output logic             need_read_o,
  output logic             need_write_o,
  output logic [31:0]      reg_addr_o,
  output logic [7:0]       reg_size_o,
  input  read_state_t      rd_state_i,
  input  write_state_t     wr_state_i,
  input  logic             bus_error_i
);

  seq_state_t       state_reg, state_next;
  logic [31:0]      cur_src_reg, cur_src_next;
  logic [31:0]      cur_dst_reg, cur_dst_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [5:0]       chunk_bytes_reg;
  logic [7:0]       size_reg;
  logic [31:0]      addr_reg;
  logic             busy_reg, done_reg, error_reg;
  logic             need_read_reg, need_write_reg;
  logic [7:0]       sel_size;
  logic [5:0]       sel_bytes;

  // The chunk is chosen from the count that will be current once RD_REQ is
  // entered, so a new chunk is ready on the same edge as the request.
  codma_chunk_sel #(.LEN_W(LEN_W)) u_chunk_sel (
    .remaining_i (remaining_next),
    .size_o      (sel_size),
    .bytes_o     (sel_bytes)
  );

  // Next-state, task bookkeeping and error classification
  always_comb begin
    state_next     = state_reg;
    cur_src_next   = cur_src_reg;
    cur_dst_next   = cur_dst_reg;
    remaining_next = remaining_reg;
    err_code_next  = err_code_reg;
    case (state_reg)
      SEQ_IDLE: begin
        if (start_i) begin
          cur_src_next   = src_addr_i;
          cur_dst_next   = dst_addr_i;
          remaining_next = len_i;
          err_code_next  = ERR_NONE;
          state_next     = SEQ_CHECK;
        end
      end
      SEQ_CHECK: begin
        if (remaining_reg == '0) begin
          state_next = SEQ_DONE;
        end else if (remaining_reg[2:0] != 3'd0) begin
          state_next    = SEQ_ERR;
          err_code_next = ERR_LEN;
        end
`ifdef CODMA_ALIGN_CHECK_EN
        else if ((cur_src_reg[2:0] != 3'd0) || (cur_dst_reg[2:0] != 3'd0)) begin
          state_next    = SEQ_ERR;
          err_code_next = ERR_ALIGN;
        end
`endif
        else begin
          state_next = SEQ_RD_REQ;
        end
      end
      SEQ_RD_REQ: begin
        if (bus_error_i) begin
          state_next    = SEQ_ERR;
          err_code_next = ERR_BUS;
        end else if (rd_state_i != RD_IDLE) begin
          state_next = SEQ_RD_WAIT;
        end
      end
      SEQ_RD_WAIT: begin
        if (bus_error_i) begin
          state_next    = SEQ_ERR;
          err_code_next = ERR_BUS;
        end else if (rd_state_i == RD_IDLE) begin
          state_next = SEQ_WR_REQ;
        end
      end
      SEQ_WR_REQ: begin
        if (bus_error_i) begin
          state_next    = SEQ_ERR;
          err_code_next = ERR_BUS;
        end else if (wr_state_i != WR_IDLE) begin
          state_next = SEQ_WR_WAIT;
        end
      end
      SEQ_WR_WAIT: begin
        if (bus_error_i) begin
          state_next    = SEQ_ERR;
          err_code_next = ERR_BUS;
        end else if (wr_state_i == WR_IDLE) begin
          remaining_next = remaining_reg - {{(LEN_W-6){1'b0}}, chunk_bytes_reg};
          cur_src_next   = cur_src_reg + {26'd0, chunk_bytes_reg};
          cur_dst_next   = cur_dst_reg + {26'd0, chunk_bytes_reg};
          state_next     = (remaining_next == '0) ? SEQ_DONE : SEQ_RD_REQ;
        end
      end
      SEQ_DONE: state_next = SEQ_IDLE;
      SEQ_ERR:  state_next = SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  // State registers; every output is decoded from the next state so it is
  // registered yet aligned with the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg       <= SEQ_IDLE;
      cur_src_reg     <= '0;
      cur_dst_reg     <= '0;
      remaining_reg   <= '0;
      err_code_reg    <= ERR_NONE;
      chunk_bytes_reg <= '0;
      size_reg        <= '0;
      addr_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      need_read_reg   <= 1'b0;
      need_write_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_src_reg    <= cur_src_next;
      cur_dst_reg    <= cur_dst_next;
      remaining_reg  <= remaining_next;
      err_code_reg   <= err_code_next;
      busy_reg       <= (state_next != SEQ_IDLE);
      done_reg       <= (state_next == SEQ_DONE);
      error_reg      <= (state_next == SEQ_ERR);
      need_read_reg  <= (state_next == SEQ_RD_REQ);
      need_write_reg <= (state_next == SEQ_WR_REQ);
      if ((state_next == SEQ_RD_REQ) || (state_next == SEQ_RD_WAIT)) begin
        addr_reg <= cur_src_next;
      end else if ((state_next == SEQ_WR_REQ) || (state_next == SEQ_WR_WAIT)) begin
        addr_reg <= cur_dst_next;
      end
      // Chunk is captured once per chunk and held through its write phase
      if ((state_next == SEQ_RD_REQ) && (state_reg != SEQ_RD_REQ)) begin
        size_reg        <= sel_size;
        chunk_bytes_reg <= sel_bytes;
      end
    end
  end

  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign error_o      = error_reg;
  assign err_code_o   = err_code_reg;
  assign need_read_o  = need_read_reg;
  assign need_write_o = need_write_reg;
  assign reg_addr_o   = addr_reg;
  assign reg_size_o   = size_reg;

endmodule

// File: tb/tb_codma_task_sequencer.sv
// tb_codma_task_sequencer: directed tasks against a queue-based model of the
// chunking rules, with emulated read/write machines.
`timescale 1ns/1ps
module tb_codma_task_sequencer;
  import read_pkg::*;
  import write_pkg::*;

  localparam int OUT_DONE = 4;
  localparam int OUT_NONE = 5;
`ifdef CODMA_ALIGN_CHECK_EN
  localparam int ALIGN_EXP = 3;
`else
  localparam int ALIGN_EXP = 4;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  src = '0;
  logic [31:0]  dst = '0;
  logic [15:0]  len = '0;
  logic         bus_error = 1'b0;
  read_state_t  rd_state = RD_IDLE;
  write_state_t wr_state = WR_IDLE;
  logic         busy, done, error, need_read, need_write;
  logic [1:0]   err_code;
  logic [31:0]  reg_addr;
  logic [7:0]   reg_size;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [7:0]  size;
  } ev_t;

  ev_t         exp_q[$];
  int          exp_outcome = OUT_NONE;
  int          outcome_cnt = 0;
  int          last_obs = -1;
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_size[$];
  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  logic [31:0] t1_addr[4] = '{32'h1000, 32'h2000, 32'h1020, 32'h2020};
  logic [31:0] t2_addr[6] = '{32'h100, 32'h800, 32'h120, 32'h820, 32'h130, 32'h830};
  logic [7:0]  t2_size[6] = '{8'd9, 8'd9, 8'd8, 8'd8, 8'd3, 8'd3};
  logic [31:0] t7_addr[4] = '{32'hFFFF_FFF0, 32'h3000, 32'h0000_0000, 32'h3010};
  logic [7:0]  t7_size[4] = '{8'd8, 8'd8, 8'd3, 8'd3};

  always #5 clk = ~clk;

  codma_task_sequencer #(.LEN_W(16)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .src_addr_i   (src),
    .dst_addr_i   (dst),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .err_code_o   (err_code),
    .need_read_o  (need_read),
    .need_write_o (need_write),
    .reg_addr_o   (reg_addr),
    .reg_size_o   (reg_size),
    .rd_state_i   (rd_state),
    .wr_state_i   (wr_state),
    .bus_error_i  (bus_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] size_of(input int b);
    return (b == 32) ? 8'd9 : (b == 16) ? 8'd16 - 8'd8 : 8'd3;
  endfunction

  // Model: expected chunk requests and final outcome of one task
  task automatic model_task(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input int abort_after_reads);
    int unsigned rem;
    logic [31:0] cs, cd;
    int b, nreads;
    ev_t e;
    exp_q.delete();
    rem = l; cs = s; cd = d; nreads = 0;
    if (l == 0) begin exp_outcome = OUT_DONE; return; end
    if ((l % 8) != 0) begin exp_outcome = 2; return; end
`ifdef CODMA_ALIGN_CHECK_EN
    if ((s % 8) != 0 || (d % 8) != 0) begin exp_outcome = 3; return; end
`endif
    while (rem != 0) begin
      b = (rem >= 32) ? 32 : (rem >= 16) ? 16 : 8;
      e.is_wr = 1'b0; e.addr = cs; e.size = size_of(b);
      exp_q.push_back(e);
      nreads++;
      if (nreads == abort_after_reads) begin exp_outcome = 1; return; end
      e.is_wr = 1'b1; e.addr = cd;
      exp_q.push_back(e);
      rem = rem - b; cs = cs + 32'(b); cd = cd + 32'(b);
    end
    exp_outcome = OUT_DONE;
  endtask

  task automatic start_task(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    obs_addr.delete();
    obs_size.delete();
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_outcome(input int target, input string name);
    int n = 0;
    while (outcome_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished"}, 32'(outcome_cnt >= target), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_error"}, 32'(error), 0);
    chk({name, "_err_code"}, 32'(err_code), 0);
    chk({name, "_need_read"}, 32'(need_read), 0);
    chk({name, "_need_write"}, 32'(need_write), 0);
    chk({name, "_reg_addr"}, reg_addr, 0);
    chk({name, "_reg_size"}, 32'(reg_size), 0);
  endtask

  // Emulated read_machine / write_machine
  initial begin : responder
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_state = RD_IDLE; wr_state = WR_IDLE; rd_cnt = 0; wr_cnt = 0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) rd_state = RD_IDLE;
        end else if (need_read && rd_state == RD_IDLE) begin
          rd_state = RD_DATA; rd_cnt = 3;
        end
        if (wr_cnt > 0) begin
          wr_cnt--;
          if (wr_cnt == 0) wr_state = WR_IDLE;
        end else if (need_write && wr_state == WR_IDLE) begin
          wr_state = WR_DATA; wr_cnt = 2;
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin : compare
    logic prev_nr, prev_nw;
    ev_t e;
    int obs;
    prev_nr = 1'b0; prev_nw = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        prev_nr = 1'b0; prev_nw = 1'b0;
      end else begin
        chk("req_exclusive", 32'(need_read & need_write), 0);
        chk("req_without_busy", 32'((need_read | need_write) & ~busy), 0);
        if (need_read && !prev_nr) begin
          obs_addr.push_back(reg_addr); obs_size.push_back(reg_size);
          $display("t=%0t read  addr=0x%08h size=%0d", $time, reg_addr, reg_size);
          if (exp_q.size() == 0 || exp_q[0].is_wr) begin
            checks++; errors++;
            $display("FAIL unexpected_read: actual addr=0x%0h required no read", reg_addr);
          end else begin
            e = exp_q.pop_front();
            chk("read_addr", reg_addr, e.addr);
            chk("read_size", 32'(reg_size), 32'(e.size));
          end
        end
        if (need_write && !prev_nw) begin
          obs_addr.push_back(reg_addr); obs_size.push_back(reg_size);
          $display("t=%0t write addr=0x%08h size=%0d", $time, reg_addr, reg_size);
          if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
            checks++; errors++;
            $display("FAIL unexpected_write: actual addr=0x%0h required no write", reg_addr);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", reg_addr, e.addr);
            chk("write_size", 32'(reg_size), 32'(e.size));
          end
        end
        if (done || error) begin
          obs = done ? OUT_DONE : int'(err_code);
          last_obs = obs;
          $display("t=%0t outcome done=%0d error=%0d code=%0d", $time, done, error, err_code);
          chk("outcome", 32'(obs), 32'(exp_outcome));
          chk("outcome_single", 32'(done & error), 0);
          chk("events_left", 32'(exp_q.size()), 0);
          chk("busy_at_end", 32'(busy), 1);
          if (done) chk("done_err_code", 32'(err_code), 0);
          outcome_cnt++;
        end
        prev_nr = need_read; prev_nw = need_write;
      end
    end
  end

  initial begin : stim
    int n, saved;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // T1: two 32-byte chunks, start-to-request latency
    model_task(32'h1000, 32'h2000, 16'h40, 0);
    start_task(32'h1000, 32'h2000, 16'h40);
    chk("t1_busy_in_check", 32'(busy), 1);
    chk("t1_no_read_in_check", 32'(need_read), 0);
    @(posedge clk); #1;
    chk("t1_start_to_read", 32'(need_read), 1);
    wait_outcome(1, "t1");
    chk("t1_outcome_lit", 32'(last_obs), 4);
    chk("t1_nreq", 32'(obs_addr.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("t1_addr_lit", (i < obs_addr.size()) ? obs_addr[i] : 32'hDEAD_BEEF, t1_addr[i]);

    // T2: 32 + 16 + 8 byte chunks
    model_task(32'h100, 32'h800, 16'h38, 0);
    start_task(32'h100, 32'h800, 16'h38);
    wait_outcome(2, "t2");
    chk("t2_nreq", 32'(obs_addr.size()), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_addr_lit", (i < obs_addr.size()) ? obs_addr[i] : 32'hDEAD_BEEF, t2_addr[i]);
      chk("t2_size_lit", (i < obs_size.size()) ? 32'(obs_size[i]) : 32'hFF, 32'(t2_size[i]));
    end

    // T3: length not a multiple of 8
    model_task(32'h1000, 32'h2000, 16'h0C, 0);
    start_task(32'h1000, 32'h2000, 16'h0C);
    wait_outcome(3, "t3");
    chk("t3_outcome_lit", 32'(last_obs), 2);
    chk("t3_no_requests", 32'(obs_addr.size()), 0);
    repeat (3) @(negedge clk);
    chk("t3_err_code_held", 32'(err_code), 2);
    chk("t3_idle_busy", 32'(busy), 0);

    // T4: zero length completes at once and clears the held error code
    model_task(32'h0, 32'h0, 16'h0, 0);
    start_task(32'h0, 32'h0, 16'h0);
    chk("t4_err_code_cleared", 32'(err_code), 0);
    wait_outcome(4, "t4");
    chk("t4_outcome_lit", 32'(last_obs), 4);

    // T5: bus error during the first read wait
    model_task(32'h1000, 32'h2000, 16'h40, 1);
    start_task(32'h1000, 32'h2000, 16'h40);
    n = 0;
    while (!(busy && !need_read && rd_state != RD_IDLE) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("t5_reach_rd_wait", 32'(n < 400), 1);
    bus_error = 1'b1;
    @(negedge clk);
    bus_error = 1'b0;
    wait_outcome(5, "t5");
    chk("t5_outcome_lit", 32'(last_obs), 1);
    chk("t5_one_request", 32'(obs_addr.size()), 1);
    @(negedge clk);
    chk("t5_busy_after", 32'(busy), 0);
    chk("t5_err_code_held", 32'(err_code), 1);

    // T6: reset during the first write wait
    model_task(32'h5000, 32'h6000, 16'h40, 0);
    start_task(32'h5000, 32'h6000, 16'h40);
    n = 0;
    while (!(busy && !need_write && wr_state != WR_IDLE) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("t6_reach_wr_wait", 32'(n < 400), 1);
    saved = outcome_cnt;
    exp_q.delete();
    exp_outcome = OUT_NONE;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("t6_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_pulse", 32'(outcome_cnt), 32'(saved));

    // T7: normal task after reset, source address wraps past 0xFFFF_FFFF
    model_task(32'hFFFF_FFF0, 32'h3000, 16'h18, 0);
    start_task(32'hFFFF_FFF0, 32'h3000, 16'h18);
    wait_outcome(saved + 1, "t7");
    chk("t7_outcome_lit", 32'(last_obs), 4);
    chk("t7_nreq", 32'(obs_addr.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t7_addr_lit", (i < obs_addr.size()) ? obs_addr[i] : 32'hDEAD_BEEF, t7_addr[i]);
      chk("t7_size_lit", (i < obs_size.size()) ? 32'(obs_size[i]) : 32'hFF, 32'(t7_size[i]));
    end

    // T8: misaligned source
    model_task(32'h1004, 32'h2000, 16'h10, 0);
    start_task(32'h1004, 32'h2000, 16'h10);
    wait_outcome(saved + 2, "t8");
    chk("t8_outcome_lit", 32'(last_obs), 32'(ALIGN_EXP));
    chk("t8_err_code", 32'(err_code), (ALIGN_EXP == 3) ? 32'd3 : 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codma_task_sequencer.md
# codma_task_sequencer

Upstream control stage of the CODMA. It accepts one copy task (source address, destination address, byte length) and splits it into bus-sized chunks of 32, 16 or 8 bytes. For each chunk it drives a request into read_machine, waits for completion, then drives the same chunk into write_machine. It reports done or error to the task issuer and never touches BUS_IF directly.

## Interface
Parameters:
- LEN_W, 16, width of task byte length and remaining-byte counter

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; one clock, synchronous, active-low
- start_i  in  1  task start strobe, sampled only in IDLE
- src_addr_i  in  32  task source byte address
- dst_addr_i  in  32  task destination byte address
- len_i  in  LEN_W  task length in bytes
- busy_o  out  1  high from the cycle after start is accepted until DONE/ERR is left
- done_o  out  1  one-cycle pulse, task completed without error
- error_o  out  1  one-cycle pulse, task aborted
- err_code_o  out  2  0 none, 1 bus error, 2 bad length, 3 misaligned; held until next accepted start
- need_read_o  out  1  read request to read_machine
- need_write_o  out  1  write request to write_machine
- reg_addr_o  out  32  chunk address (source in read phase, destination in write phase)
- reg_size_o  out  8  bus size code of current chunk
- rd_state_i  in  read_state_t  read_machine current state
- wr_state_i  in  write_state_t  write_machine current state
- bus_error_i  in  1  bus error indication

## Operation
- States: IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERR.
- IDLE:
  - start_i=1 latches src, dst, len into cur_src, cur_dst, remaining, clears err_code_o, then goes to CHECK.
- CHECK:
  - remaining==0 goes to DONE.
  - remaining[2:0]!=0 goes to ERR with code 2.
  - Otherwise goes to RD_REQ.
- Chunk selection from remaining:
  - ≥32 gives size 9, 32 bytes.
  - else ≥16 gives size 8, 16 bytes.
  - else gives size 3, 8 bytes.
  - Chunk is registered on entry to RD_REQ and held through WR_WAIT.
- RD_REQ:
  - need_read_o=1 and reg_addr_o=cur_src.
  - Stays until rd_state_i!=RD_IDLE, then goes to RD_WAIT with need_read_o=0.
- RD_WAIT:
  - rd_state_i==RD_IDLE goes to WR_REQ.
- WR_REQ and WR_WAIT mirror RD_REQ and RD_WAIT:
  - They use need_write_o, reg_addr_o=cur_dst and wr_state_i.
- End of WR_WAIT:
  - remaining -= chunk bytes, cur_src += bytes, cur_dst += bytes.
  - remaining==0 after the update goes to DONE; otherwise goes to RD_REQ.
- Address arithmetic is 32-bit modulo; wrap past 0xFFFF_FFFF is not flagged.
- bus_error_i=1 in any of RD_REQ, RD_WAIT, WR_REQ, WR_WAIT goes to ERR with code 1. Bus error takes precedence over a same-cycle completion.
- DONE pulses done_o and goes to IDLE. ERR pulses error_o and goes to IDLE.
- start_i outside IDLE is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: busy, done, error, err_code, need_read, need_write, reg_addr, reg_size.
  - Internal counters are 0.
- All outputs are registered.
- Start to first need_read_o high is 2 cycles (IDLE→CHECK→RD_REQ).
- need_read_o/need_write_o stay high for at least 1 cycle and drop the cycle after the machine leaves IDLE. No second request is raised within a chunk.
- Latency per chunk is 2 request cycles plus the read_machine and write_machine durations.
- DONE/ERR each last exactly 1 cycle. busy_o is 1 during DONE/ERR and 0 in IDLE.
- Reset mid-task:
  - Returns to IDLE on the next edge with all outputs 0.
  - Partial progress is discarded and no done/error pulse is given.

## Configuration
- CODMA_ALIGN_CHECK_EN defined:
  - CHECK also requires src_addr and dst_addr to be 8-byte aligned ([2:0]==0).
  - A failure goes to ERR with code 3. The length check has priority over alignment.
- Undefined: the address check is absent and code 3 is never produced.

## Structure
- codma_pkg holds:
  - seq_state_t.
  - Size codes SIZE_8W=9, SIZE_4W=8, SIZE_2W=3.
  - Byte constants 32/16/8.
  - Error code constants.
- read_state_t and write_state_t stay in read_pkg and write_pkg.
- One sub-module, codma_chunk_sel: combinational remaining → {size code, chunk bytes}.

## Test plan
- len=0x40, src=0x1000, dst=0x2000 → two size-9 chunks.
  - reg_addr_o sequence: 0x1000, 0x2000, 0x1020, 0x2020.
  - done_o pulses once, err_code_o=0.
- len=0x38 → chunks 32, 16, 8 with sizes 9, 8, 3 and addresses advancing by 0x20 then 0x10.
- len=0x0C → error_o pulse, err_code_o=2, need_read_o never asserted.
- bus_error_i pulse during RD_WAIT of chunk 1 of len=0x40 → ERR with code 1, need_write_o never asserted, busy_o=0 afterwards.
- reset_n_i low during WR_WAIT → next cycle all outputs 0 and state IDLE; a new start afterwards runs normally.
- With CODMA_ALIGN_CHECK_EN, src=0x1004, len=0x10 → err_code_o=3. Without the macro the same stimulus completes with done_o.
